// File: rtl/fifo_rd_unpacker_pkg.sv
// Shared helpers for the FIFO read-side unpacker: word/byte ratio, parameter
// sanity check and the byte-lane selector used to serialise a word.
package fifo_rd_unpacker_pkg;

    // Widest FIFO word the selector can handle.
    localparam int MAX_W = 512;

    function automatic int ratio_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic bit widths_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w <= MAX_W) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

    // Returns lane idx of word in emission order: idx 0 is the first byte sent.
    function automatic logic [MAX_W-1:0] select_byte(
        input logic [MAX_W-1:0] word,
        input int               idx,
        input int               out_w,
        input int               ratio,
        input bit               msb_first
    );
        int               slot;
        logic [MAX_W-1:0] mask;
        slot = msb_first ? (ratio - 1 - idx) : idx;
        mask = (MAX_W'(1) << out_w) - MAX_W'(1);
        return (word >> (slot * out_w)) & mask;
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker.sv
// Drains wide words from a standard-mode FIFO read port and re-serialises them
// as OUT_W-bit bytes on a valid/ready stream, with a two-word prefetch buffer.
module fifo_rd_unpacker
    import fifo_rd_unpacker_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic [IN_W-1:0]  fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    localparam int RATIO = ratio_of(IN_W, OUT_W);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
        $error("fifo_rd_unpacker: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    logic [IN_W-1:0]  cur;
    logic [IN_W-1:0]  nxt;
    logic             cur_v;
    logic             nxt_v;
    logic             rd_pend;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             on_last;
    logic             fire;
    logic             last_fire;

    // Stream handshake: a byte transfers on a rising edge where m_valid and
    // m_ready are both high; while m_valid is high and m_ready low, m_data,
    // m_valid and m_last hold. m_valid never waits on m_ready.
    assign on_last   = (idx == IDX_LAST);
    assign fire      = cur_v & m_ready & ~srst;
    assign last_fire = fire & on_last;

    // One read in flight at most, and only when the nxt slot is guaranteed free
    // to absorb the returning word.
    assign fifo_rd_en = en & ~fifo_empty & ~rd_pend & ~nxt_v & ~srst;

    assign m_valid  = cur_v & ~srst;
    assign m_last   = cur_v & on_last & ~srst;
    assign busy     = (rd_pend | cur_v | nxt_v) & ~srst;
    assign word_cnt = cnt;

    always_comb begin
        m_data = '0;
        if (!srst) begin
            m_data = OUT_W'(select_byte(MAX_W'(cur), int'(idx), OUT_W, RATIO, MSB_FIRST != 0));
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cur     <= '0;
            nxt     <= '0;
            cur_v   <= 1'b0;
            nxt_v   <= 1'b0;
            rd_pend <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (fire && !on_last) begin
                idx <= idx + 1'b1;
            end
            if (last_fire) begin
                // Word finished: refill cur from nxt first so ordering holds,
                // and let a returning word slide into the vacated nxt.
                cnt <= cnt + 1'b1;
                idx <= '0;
                if (nxt_v) begin
                    cur   <= nxt;
                    cur_v <= 1'b1;
                    nxt_v <= rd_pend;
                    if (rd_pend) begin
                        nxt <= fifo_dout;
                    end
                end else if (rd_pend) begin
                    cur   <= fifo_dout;
                    cur_v <= 1'b1;
                end else begin
                    cur_v <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!cur_v) begin
                    cur   <= fifo_dout;
                    cur_v <= 1'b1;
                    idx   <= '0;
                end else begin
                    nxt   <= fifo_dout;
                    nxt_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: behavioural FIFO, byte-order reference model and
// per-scenario tasks with inline comparisons.
module tb_fifo_rd_unpacker;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;
    localparam int RATIO = IN_W / OUT_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic srst;
    logic en;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- MSB-first DUT ----------------
    logic [IN_W-1:0]  fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] word_cnt;
    logic             busy;

    fifo_rd_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .srst(srst), .en(en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .word_cnt(word_cnt), .busy(busy)
    );

    // ---------------- LSB-first DUT ----------------
    logic [IN_W-1:0]  lsb_fifo_dout;
    logic             lsb_fifo_empty;
    logic             lsb_fifo_rd_en;
    logic [OUT_W-1:0] lsb_m_data;
    logic             lsb_m_valid;
    logic             lsb_m_ready;
    logic             lsb_m_last;
    logic [CNT_W-1:0] lsb_word_cnt;
    logic             lsb_busy;

    fifo_rd_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0), .CNT_W(CNT_W)) dut_lsb (
        .clk(clk), .srst(srst), .en(en),
        .fifo_dout(lsb_fifo_dout), .fifo_empty(lsb_fifo_empty), .fifo_rd_en(lsb_fifo_rd_en),
        .m_data(lsb_m_data), .m_valid(lsb_m_valid), .m_ready(lsb_m_ready), .m_last(lsb_m_last),
        .word_cnt(lsb_word_cnt), .busy(lsb_busy)
    );

    // ---------------- behavioural standard-mode FIFOs ----------------
    logic [IN_W-1:0] fifo_q[$];
    logic [IN_W-1:0] lsb_q[$];

    assign fifo_empty     = (fifo_q.size() == 0);
    assign lsb_fifo_empty = (lsb_q.size() == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        if (lsb_fifo_rd_en && lsb_q.size() > 0) lsb_fifo_dout <= lsb_q.pop_front();
    end

    // ---------------- reference model / scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    logic             exp_last_q[$];
    logic [OUT_W-1:0] obs_q[$];
    logic             obs_last_q[$];
    int               exp_words;
    int               checks;
    int               passed;

    // Byte k of a word in emission order.
    function automatic logic [OUT_W-1:0] model_byte(input logic [IN_W-1:0] w, input int k, input bit msb_first);
        int pos;
        pos = msb_first ? (RATIO - 1 - k) : k;
        return OUT_W'(w >> (pos * OUT_W));
    endfunction

    function automatic int stream_errs(input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size()) errs++;
            else if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== exp_last_q[i]) errs++;
        end
        return errs;
    endfunction

    task automatic push_word(input logic [IN_W-1:0] w);
        fifo_q.push_back(w);
        for (int k = 0; k < RATIO; k++) begin
            exp_q.push_back(model_byte(w, k, 1'b1));
            exp_last_q.push_back(k == RATIO - 1);
        end
        exp_words++;
    endtask

    // ---------------- driver ----------------
    int n_rd, rd_adjacent, rd_empty, over_reads, gaps, stall_changes;
    int first_rd_cyc, first_valid_cyc;

    task automatic reset_dut();
        @(negedge clk);
        srst = 1'b1; en = 1'b1; m_ready = 1'b0; lsb_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        fifo_q.delete(); lsb_q.delete(); exp_q.delete(); exp_last_q.delete();
        exp_words = 0;
        srst = 1'b0;
    endtask

    // Runs a fixed number of cycles from a falling edge, accepting bytes with
    // probability ready_pct and recording stream statistics.
    task automatic run_stream(input int ready_pct, input int cycles, input bit drop_en);
        logic             prev_rd, prev_stall, prev_valid, prev_last;
        logic [OUT_W-1:0] prev_data;
        int               held, done, exp_total;
        obs_q.delete(); obs_last_q.delete();
        n_rd = 0; rd_adjacent = 0; rd_empty = 0; over_reads = 0; gaps = 0; stall_changes = 0;
        first_rd_cyc = -1; first_valid_cyc = -1;
        prev_rd = 1'b0; prev_stall = 1'b0; prev_valid = 1'b0; prev_last = 1'b0; prev_data = '0;
        done = 0; exp_total = exp_q.size();
        for (int c = 0; c < cycles; c++) begin
            if (drop_en && prev_rd) en = 1'b0;
            m_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            // Words captured in the DUT and not yet fully emitted.
            held = (n_rd - (prev_rd ? 1 : 0)) - done;
            if (fifo_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = c;
                if (prev_rd) rd_adjacent++;
                if (fifo_empty) rd_empty++;
                if (held >= 2) over_reads++;
                n_rd++;
            end
            if (prev_stall && (m_valid !== prev_valid || m_data !== prev_data || m_last !== prev_last))
                stall_changes++;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (!m_valid && first_valid_cyc >= 0 && obs_q.size() < exp_total) gaps++;
            if (m_valid && m_ready) begin
                obs_q.push_back(m_data);
                obs_last_q.push_back(m_last);
                if (m_last) done++;
            end
            prev_rd = fifo_rd_en; prev_stall = m_valid && !m_ready;
            prev_valid = m_valid; prev_data = m_data; prev_last = m_last;
            @(negedge clk);
        end
        m_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        push_word(16'hA5A5);
        push_word(16'h0F0F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en cyc%0d: got %b want 0", i, fifo_rd_en); else passed++;
            checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid cyc%0d: got %b want 0", i, m_valid); else passed++;
            checks++; if (word_cnt !== '0) $display("FAIL reset_word_cnt cyc%0d: got %0d want 0", i, word_cnt); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy); else passed++;
        end
    endtask

    task automatic test_order();
        logic [OUT_W-1:0] want_b[4];
        logic             want_l[4];
        logic [OUT_W-1:0] got_b;
        logic             got_l;
        want_b = '{8'h69, 8'h69, 8'h12, 8'h34};
        want_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset_dut();
        push_word(16'h6969);
        push_word(16'h1234);
        run_stream(100, 12, 1'b0);
        checks++; if (obs_q.size() != 4) $display("FAIL order_count: got %0d want 4", obs_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            got_b = (i < obs_q.size()) ? obs_q[i] : 8'h00;
            got_l = (i < obs_last_q.size()) ? obs_last_q[i] : 1'bx;
            checks++; if (got_b !== want_b[i] || got_l !== want_l[i])
                $display("FAIL order_byte%0d: got %h/last=%b want %h/last=%b", i, got_b, got_l, want_b[i], want_l[i]);
            else passed++;
        end
        checks++; if (word_cnt !== CNT_W'(exp_words)) $display("FAIL order_word_cnt: got %0d want %0d", word_cnt, exp_words); else passed++;
        checks++; if (first_rd_cyc < 0 || first_valid_cyc - first_rd_cyc != 2)
            $display("FAIL order_latency: got %0d want 2", first_valid_cyc - first_rd_cyc); else passed++;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL order_idle: got valid=%b busy=%b want 0/0", m_valid, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int errs;
        reset_dut();
        for (int i = 0; i < 64; i++) push_word(IN_W'($urandom));
        run_stream(100, 140, 1'b0);
        errs = stream_errs(128);
        checks++; if (obs_q.size() != 128) $display("FAIL b2b_count: got %0d want 128", obs_q.size()); else passed++;
        checks++; if (errs != 0) $display("FAIL b2b_stream: got %0d bad bytes want 0", errs); else passed++;
        checks++; if (gaps != 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else passed++;
        checks++; if (rd_adjacent != 0) $display("FAIL b2b_rd_adjacent: got %0d want 0", rd_adjacent); else passed++;
        checks++; if (rd_empty != 0) $display("FAIL b2b_rd_empty: got %0d want 0", rd_empty); else passed++;
        checks++; if (n_rd != 64) $display("FAIL b2b_reads: got %0d want 64", n_rd); else passed++;
        checks++; if (word_cnt !== CNT_W'(64)) $display("FAIL b2b_word_cnt: got %0d want 64", word_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        int errs;
        reset_dut();
        for (int i = 0; i < 100; i++) push_word(IN_W'($urandom));
        run_stream(50, 800, 1'b0);
        errs = stream_errs(200);
        checks++; if (obs_q.size() != 200) $display("FAIL bp_count: got %0d want 200", obs_q.size()); else passed++;
        checks++; if (errs != 0) $display("FAIL bp_stream: got %0d bad bytes want 0", errs); else passed++;
        checks++; if (stall_changes != 0) $display("FAIL bp_stall_stable: got %0d changes want 0", stall_changes); else passed++;
        checks++; if (over_reads != 0) $display("FAIL bp_read_while_full: got %0d want 0", over_reads); else passed++;
        checks++; if (rd_adjacent != 0) $display("FAIL bp_rd_adjacent: got %0d want 0", rd_adjacent); else passed++;
        checks++; if (word_cnt !== CNT_W'(exp_words)) $display("FAIL bp_word_cnt: got %0d want %0d", word_cnt, exp_words); else passed++;
    endtask

    task automatic test_empty();
        reset_dut();
        for (int i = 0; i < 3; i++) push_word(IN_W'($urandom));
        run_stream(100, 20, 1'b0);
        checks++; if (obs_q.size() != 6) $display("FAIL empty_count: got %0d want 6", obs_q.size()); else passed++;
        checks++; if (stream_errs(6) != 0) $display("FAIL empty_stream: got %0d bad bytes want 0", stream_errs(6)); else passed++;
        checks++; if (m_valid !== 1'b0) $display("FAIL empty_valid_drop: got %b want 0", m_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy); else passed++;
        checks++; if (word_cnt !== CNT_W'(3)) $display("FAIL empty_word_cnt: got %0d want 3", word_cnt); else passed++;
    endtask

    task automatic test_en_pending();
        reset_dut();
        for (int i = 0; i < 4; i++) push_word(IN_W'($urandom));
        run_stream(100, 20, 1'b1);
        checks++; if (obs_q.size() != 2) $display("FAIL en_count: got %0d want 2", obs_q.size()); else passed++;
        checks++; if (stream_errs(2) != 0) $display("FAIL en_stream: got %0d bad bytes want 0", stream_errs(2)); else passed++;
        checks++; if (n_rd != 1) $display("FAIL en_reads: got %0d want 1", n_rd); else passed++;
        checks++; if (fifo_q.size() != 3) $display("FAIL en_fifo_left: got %0d want 3", fifo_q.size()); else passed++;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL en_idle: got busy=%b valid=%b want 0/0", busy, m_valid); else passed++;
        checks++; if (word_cnt !== CNT_W'(1)) $display("FAIL en_word_cnt: got %0d want 1", word_cnt); else passed++;
    endtask

    task automatic test_mid_reset();
        reset_dut();
        for (int i = 0; i < 8; i++) push_word(IN_W'($urandom));
        run_stream(100, 6, 1'b0);
        srst = 1'b1;
        fifo_q.delete(); exp_q.delete(); exp_last_q.delete(); exp_words = 0;
        @(negedge clk);
        srst = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) $display("FAIL mid_rst_valid: got valid=%b last=%b want 0/0", m_valid, m_last); else passed++;
        checks++; if (word_cnt !== '0) $display("FAIL mid_rst_word_cnt: got %0d want 0", word_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
        @(negedge clk);
        push_word(16'h5A3C);
        run_stream(100, 10, 1'b0);
        checks++; if (obs_q.size() != 2 || stream_errs(2) != 0)
            $display("FAIL mid_rst_stream: got %0d bytes (%0d bad) want 2 (0 bad)", obs_q.size(), stream_errs(2)); else passed++;
        checks++; if (word_cnt !== CNT_W'(1)) $display("FAIL mid_rst_word_cnt_after: got %0d want 1", word_cnt); else passed++;
    endtask

    task automatic test_lsb_first();
        logic [IN_W-1:0]  w[2];
        logic [OUT_W-1:0] got_b[$];
        logic             got_l[$];
        int               errs;
        reset_dut();
        w[0] = 16'hABCD;
        w[1] = IN_W'($urandom);
        lsb_q.push_back(w[0]);
        lsb_q.push_back(w[1]);
        lsb_m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (lsb_m_valid && lsb_m_ready) begin
                got_b.push_back(lsb_m_data);
                got_l.push_back(lsb_m_last);
            end
            @(negedge clk);
        end
        lsb_m_ready = 1'b0;
        checks++; if (got_b.size() != 4) $display("FAIL lsb_count: got %0d want 4", got_b.size()); else passed++;
        checks++; if (got_b.size() < 1 || got_b[0] !== 8'hCD) $display("FAIL lsb_first_byte: got %h want cd", (got_b.size() > 0) ? got_b[0] : 8'h00); else passed++;
        checks++; if (got_b.size() < 2 || got_b[1] !== 8'hAB) $display("FAIL lsb_second_byte: got %h want ab", (got_b.size() > 1) ? got_b[1] : 8'h00); else passed++;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= got_b.size()) errs++;
            else if (got_b[i] !== model_byte(w[i/RATIO], i % RATIO, 1'b0) || got_l[i] !== (i % RATIO == RATIO - 1)) errs++;
        end
        checks++; if (errs != 0) $display("FAIL lsb_stream: got %0d bad bytes want 0", errs); else passed++;
        checks++; if (lsb_word_cnt !== CNT_W'(2) || lsb_busy !== 1'b0)
            $display("FAIL lsb_done: got cnt=%0d busy=%b want 2/0", lsb_word_cnt, lsb_busy); else passed++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        srst = 1'b1; en = 1'b1; m_ready = 1'b0; lsb_m_ready = 1'b0;
        checks = 0; passed = 0; exp_words = 0;
        test_reset();
        test_order();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_en_pending();
        test_mid_reset();
        test_lsb_first();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Read-side companion to the 8-in/16-out width-converting FIFO (fifo_generator_1).
- Drains 16-bit words from the FIFO's standard-mode read port (dout valid one cycle after rd_en) and re-serialises each word into 8-bit bytes.
- Bytes leave on a valid/ready stream toward downstream logic.
- Two-word prefetch buffer: sustained one byte per clock with no bubbles while the FIFO is non-empty and m_ready is held high.

Parameters:
- IN_W, 16, FIFO read-data width; must be an integer multiple of OUT_W.
- OUT_W, 8, output byte width.
- MSB_FIRST, 1, 1 = emit the most significant byte of each word first; 0 = least significant byte first.
- CNT_W, 16, width of the word_cnt counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- srst  in  1  synchronous reset, active-high.
- en  in  1  when low, no new FIFO reads are issued; buffered data still drains.
- fifo_dout  in  IN_W  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe (combinational).
- m_data  out  OUT_W  output byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  high with the final byte of each word.
- word_cnt  out  CNT_W  count of words fully emitted; wraps modulo 2^CNT_W.
- busy  out  1  high when a read is pending or either buffer register is occupied.

Behaviour:
- Derived constant: RATIO = IN_W/OUT_W (2 at defaults).
- Storage:
  - cur register with cur_v flag and byte index idx (0..RATIO-1).
  - nxt register with nxt_v flag.
  - rd_pend flag: a read was issued last cycle.
- Reset (srst=1 at a clock edge): cur_v=0, nxt_v=0, rd_pend=0, idx=0, word_cnt=0.
  - Outputs in reset: m_valid=0, m_last=0, busy=0, fifo_rd_en=0.
  - m_data is don't-care; it is driven 0 in reset.
- fifo_rd_en = en & !fifo_empty & !rd_pend & !nxt_v & !srst.
  - At most one outstanding read, so fifo_rd_en is never asserted on back-to-back cycles.
  - Never asserted when fifo_empty=1; underflow is impossible by construction.
- Read return: on the cycle after fifo_rd_en, rd_pend=1 and fifo_dout is captured at the clock edge.
  - Into cur (idx:=0) if cur is empty, or if cur is completing its last byte this cycle.
  - Otherwise into nxt.
- Output:
  - m_valid = cur_v.
  - m_data = slice idx of cur: from MSB when MSB_FIRST=1, from LSB otherwise.
  - m_last = cur_v & (idx==RATIO-1).
- Handshake (m_valid & m_ready):
  - Not last byte: idx increments.
  - Last byte: word_cnt increments and cur is reloaded with priority nxt > returning read data; cur_v clears only if neither source is available.
  - m_data, m_valid and m_last are held stable while m_valid & !m_ready.
- Simultaneous events: a last-byte handshake, a read return and nxt_v in the same cycle:
  - cur := nxt;
  - nxt := returning word;
  - ordering is preserved and no word is dropped.
- Latency: first byte is valid two cycles after fifo_rd_en, i.e. FIFO non-empty at cycle t gives m_valid at t+2.
- Throughput: with m_ready=1 and the FIFO non-empty, one byte per clock indefinitely.
- en deasserted mid-stream: a pending read still completes and is captured; remaining bytes drain; then m_valid falls.
- srst mid-operation: all buffered and pending data is discarded; no byte is emitted on the cycle after reset.
- busy = rd_pend | cur_v | nxt_v.

Decomposition:
- Shared package holds:
  - RATIO computation;
  - byte-select function (word, idx, MSB_FIRST → byte);
  - elaboration check that IN_W % OUT_W == 0 and RATIO >= 2.
- No sub-module; single flat block.

Test Plan:
- Reset: hold srst for 3 cycles with FIFO non-empty → fifo_rd_en=0, m_valid=0, word_cnt=0 throughout.
- Order, MSB_FIRST=1, m_ready=1: FIFO words 0x6969, 0x1234 → bytes 0x69, 0x69, 0x12, 0x34; m_last on the 2nd and 4th bytes; word_cnt=2; first m_valid 2 cycles after the first fifo_rd_en.
- Throughput: 64 words, m_ready=1 → 128 consecutive m_valid cycles with no gaps; fifo_rd_en never high on adjacent cycles; word_cnt=64.
- Backpressure: random m_ready (50%) over 100 words → byte stream identical to the reference order; m_data stable while stalled; no FIFO read while nxt_v=1.
- Empty and en control:
  - FIFO empties after 3 words → m_valid drops after byte 6, busy=0.
  - en=0 asserted while a read is pending → that word is still emitted, then no further reads.
- Mid-stream srst, plus MSB_FIRST=0 run with 0xABCD → after reset, no stale bytes and word_cnt=0; LSB-first run emits 0xCD, then 0xAB.
